// File: rtl/alu_op_sequencer_if.sv
`default_nettype none
// =============================================================================
// Module   : alu_op_sequencer_if
// Brief    : Button, ALU command/response and display bundle for the sequencer.
// Revision : 1.0 - initial release
// =============================================================================
interface alu_op_sequencer_if;
   logic [20:0] pb;
   logic        alu_en;
   logic [2:0]  alu_ctrl;
   logic        alu_cin;
   logic [3:0]  alu_a;
   logic [3:0]  alu_b;
   logic [3:0]  alu_m;
   logic        alu_s;
   logic        alu_o;
   logic        alu_cout;
   logic [3:0]  res_m;
   logic [2:0]  res_flags;
   logic [2:0]  state_code;
   logic        done;

   modport master (
      input  pb, alu_m, alu_s, alu_o, alu_cout,
      output alu_en, alu_ctrl, alu_cin, alu_a, alu_b,
             res_m, res_flags, state_code, done
   );

   modport slave (
      output pb, alu_m, alu_s, alu_o, alu_cout,
      input  alu_en, alu_ctrl, alu_cin, alu_a, alu_b,
             res_m, res_flags, state_code, done
   );
endinterface
`default_nettype wire

// File: rtl/alu_op_sequencer.sv
`default_nettype none
// =============================================================================
// Module   : alu_op_sequencer
// Brief    : Hex-key front end that loads A, B and op, pulses the ALU, and
//            captures its result for display.
// Revision : 1.0 - initial release
// =============================================================================
module alu_op_sequencer #(
   parameter int SYNC_STAGES   = 2,
   parameter int SETTLE_CYCLES = 1
) (
   input  wire logic          hz100,
   input  wire logic          reset,
   alu_op_sequencer_if.master bus
);
   localparam int c_fill_w = $clog2(SYNC_STAGES + 1);
   localparam int c_cnt_w  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [c_fill_w-1:0] c_fill_full = c_fill_w'(SYNC_STAGES);
   localparam logic [c_cnt_w-1:0]  c_cnt_last  = c_cnt_w'(SETTLE_CYCLES - 1);

   typedef enum logic [2:0] {
      ST_GET_A  = 3'd0,
      ST_GET_B  = 3'd1,
      ST_GET_OP = 3'd2,
      ST_EXEC   = 3'd3,
      ST_SHOW   = 3'd4
   } state_t;

   logic [17:0]         r_sync [SYNC_STAGES];
   logic [17:0]         r_prev;
   logic [17:0]         r_arm;
   logic [c_fill_w-1:0] r_fill;
   logic [17:0]         w_level;
   logic [17:0]         w_pulse;
   logic                w_unused;

   logic                w_clear;
   logic                w_enter;
   logic                w_digit_hit;
   logic [3:0]          w_digit;

   state_t              r_state;
   state_t              w_next;
   logic                w_capture;
   logic [c_cnt_w-1:0]  r_cnt;
   logic [3:0]          r_a;
   logic [3:0]          r_b;
   logic [3:0]          r_op;
   logic [3:0]          r_res;
   logic [2:0]          r_flags;
   logic                r_done;

   assign w_unused = &{1'b0, bus.pb[20:18]};
   assign w_level  = r_sync[SYNC_STAGES-1];

   // A bit is armed only after a genuine post-reset low sample, so a key held
   // through reset cannot fire until it has been released.
   always_ff @(posedge hz100) begin
      if (reset) begin
         for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
         r_prev <= '0;
         r_arm  <= '0;
         r_fill <= '0;
      end else begin
         r_sync[0] <= bus.pb[17:0];
         for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
         r_prev <= w_level;
         if (r_fill == c_fill_full) r_arm <= r_arm | ~w_level;
         else                       r_fill <= r_fill + c_fill_w'(1);
      end
   end

   assign w_pulse = w_level & ~r_prev & r_arm;

   always_comb begin
      w_digit_hit = 1'b0;
      w_digit     = 4'd0;
      for (int i = 15; i >= 0; i--) begin
         if (w_pulse[i]) begin
            w_digit_hit = 1'b1;
            w_digit     = 4'(i);
         end
      end
   end

   assign w_clear = w_pulse[17];
   assign w_enter = w_pulse[16] & ~w_digit_hit;

   always_ff @(posedge hz100) begin
      if (reset) r_state <= ST_GET_A;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next    = r_state;
      w_capture = 1'b0;
      if (w_clear) begin
         w_next = ST_GET_A;
      end else begin
         case (r_state)
            ST_GET_A:  if (w_enter) w_next = ST_GET_B;
            ST_GET_B:  if (w_enter) w_next = ST_GET_OP;
            ST_GET_OP: if (w_enter) w_next = ST_EXEC;
            ST_EXEC: begin
               if (r_cnt == c_cnt_last) begin
                  w_next    = ST_SHOW;
                  w_capture = 1'b1;
               end
            end
            ST_SHOW: begin
               if (w_digit_hit)  w_next = ST_GET_B;
               else if (w_enter) w_next = ST_EXEC;
            end
            default: w_next = ST_GET_A;
         endcase
      end
   end

   // ALU outputs are only looked at on the capture cycle inside EXEC.
   always_ff @(posedge hz100) begin
      if (reset || w_clear) begin
         r_a     <= '0;
         r_b     <= '0;
         r_op    <= '0;
         r_res   <= '0;
         r_flags <= '0;
         r_done  <= 1'b0;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            ST_GET_A:  if (w_digit_hit) r_a <= w_digit;
            ST_GET_B:  if (w_digit_hit) r_b <= w_digit;
            ST_GET_OP: begin
               if (w_digit_hit) r_op  <= w_digit;
               if (w_enter)     r_cnt <= '0;
            end
            ST_EXEC: begin
               r_cnt <= r_cnt + c_cnt_w'(1);
               if (w_capture) begin
                  r_res   <= bus.alu_m;
                  r_flags <= {bus.alu_s, bus.alu_o, bus.alu_cout};
                  r_done  <= 1'b1;
               end
            end
            ST_SHOW: begin
               if (w_digit_hit) begin
                  r_a    <= w_digit;
                  r_b    <= '0;
                  r_op   <= '0;
                  r_done <= 1'b0;
               end else if (w_enter) begin
                  r_cnt  <= '0;
                  r_done <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.alu_en     = (r_state == ST_EXEC);
   assign bus.alu_a      = r_a;
   assign bus.alu_b      = r_b;
   assign bus.alu_ctrl   = r_op[2:0];
   assign bus.alu_cin    = r_op[3];
   assign bus.res_m      = r_res;
   assign bus.res_flags  = r_flags;
   assign bus.state_code = r_state;
   assign bus.done       = r_done;
endmodule
`default_nettype wire
